// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4:1 bit-mux channel among four requesters.
//   The current owner keeps the channel for up to BURST_LEN accepted beats, or
//   until it drops its request. Then the priority pointer moves past it and a new
//   owner is chosen at the same edge, so there is no idle cycle between owners.
//
// Parameters
//   BURST_LEN  maximum accepted beats per grant, legal range 1..15
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   req[3:0]   in   level request per requester, held while it has data
//   I[3:0]     in   data bit per requester
//   ready      in   sink accepts a beat this cycle
//   S[1:0]     out  registered mux select (index of current owner)
//   gnt[3:0]   out  registered one-hot grant, zero when idle
//   out        out  I[S] while out_valid, else 0
//   out_valid  out  gnt != 0 and the owner still requests
module mux4_rr_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] I,
  input  logic       ready,
  output logic [1:0] S,
  output logic [3:0] gnt,
  output logic       out,
  output logic       out_valid
);

  localparam logic [3:0] CntLast = 4'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;

  logic       beat;
  logic       owner_drop;
  logic       burst_done;
  logic       release_own;
  logic [1:0] arb_ptr;
  logic       arb_found;
  logic [1:0] arb_idx;

  // Search starting at ptr and wrapping; returns {found, index}.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      // Walk from the lowest priority upward so the last hit is the winner.
      idx = 2'(p + 2'(k));
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Downstream handshake is combinational from registered select/grant.
  assign out_valid = (gnt_q != 4'b0000) && req[s_q];
  assign out       = out_valid & I[s_q];
  assign S         = s_q;
  assign gnt       = gnt_q;

  always_comb begin
    beat        = out_valid && ready;
    // A dropped request means out_valid is low, so no beat can coincide with it.
    owner_drop  = (state_q == StOwn) && !req[s_q];
    burst_done  = (state_q == StOwn) && beat && (cnt_q == CntLast);
    release_own = owner_drop || burst_done;
    // On release the old owner becomes lowest priority for this very edge.
    arb_ptr     = release_own ? 2'(s_q + 2'd1) : ptr_q;
    {arb_found, arb_idx} = arbitrate(req, arb_ptr);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d = StOwn;
          s_d     = arb_idx;
          gnt_d   = 4'b0001 << arb_idx;
          cnt_d   = 4'd0;
        end
      end
      StOwn: begin
        if (release_own) begin
          ptr_d = arb_ptr;
          if (arb_found) begin
            state_d = StOwn;
            s_d     = arb_idx;
            gnt_d   = 4'b0001 << arb_idx;
            cnt_d   = 4'd0;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            cnt_d   = 4'd0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 4'd1;
        end
        // ready low: everything holds, the grant never times out.
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= 2'd0;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
